// File: rtl/vector_op_controller_pkg.sv
// Shared type definitions for the vector operation controller: FSM state
// encodings and operation-mode codes.
package vec_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INPUT_A = 3'd1,
        ST_INPUT_B = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DISPLAY = 3'd4,
        ST_ERROR   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DOT = 2'd3
    } op_mode_e;

endpackage

// File: rtl/cycle_timer.sv
// Cycle counter for the COMPUTE watchdog; expired flags the LIMIT-th enabled
// cycle counted from the cycle in which clear is asserted.
module cycle_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_cur;

    // clear takes effect in its own cycle so that cycle counts as zero
    always_comb begin
        count_cur = clear ? '0 : count_q;
        expired   = enable && (count_cur == CNT_W'(LIMIT - 1));
        count_d   = enable ? count_cur + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vector_op_controller.sv
// Sequences loading of two vectors into memory, launches a compute engine,
// and presents its result or a timeout error.
module vector_op_controller
    import vec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned VEC_LEN     = 8,
    parameter int unsigned ADDR_W      = $clog2(2 * VEC_LEN),
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op_mode,
    input  logic              abort,
    input  logic              restart,
    input  logic [DATA_W-1:0] input_value,
    input  logic              input_value_ready,
    output logic              input_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mode_latched,
    output logic              comp_start,
    input  logic              comp_done,
    input  logic [DATA_W-1:0] comp_result,
    output logic              display_enable,
    output logic [DATA_W-1:0] display_value,
    output logic              error,
    output logic [2:0]        state
);

    localparam int unsigned IDX_W = $clog2(VEC_LEN);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    op_mode_e          mode_q, mode_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              comp_start_q, comp_start_d;
    logic              timer_expired;

    cycle_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (comp_start_q),
        .enable  (state_q == ST_COMPUTE),
        .expired (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mode_d       = mode_q;
        wr_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        result_d     = result_q;
        comp_start_d = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_INPUT_A;
                        mode_d  = op_mode_e'(op_mode);
                        idx_d   = '0;
                    end
                end
                ST_INPUT_A, ST_INPUT_B: begin
                    if (input_value_ready) begin
                        wr_d    = 1'b1;
                        wdata_d = input_value;
                        addr_d  = (state_q == ST_INPUT_B) ? ADDR_W'(VEC_LEN) + ADDR_W'(idx_q)
                                                          : ADDR_W'(idx_q);
                        if (idx_q == IDX_W'(VEC_LEN - 1)) begin
                            idx_d = '0;
                            if (state_q == ST_INPUT_A) begin
                                state_d = ST_INPUT_B;
                            end else begin
                                state_d      = ST_COMPUTE;
                                comp_start_d = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    // done is checked first so it wins over a same-cycle timeout
                    if (comp_done) begin
                        result_d = comp_result;
                        state_d  = ST_DISPLAY;
                    end else if (timer_expired) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_DISPLAY, ST_ERROR: begin
                    if (restart) begin
                        state_d = ST_INPUT_A;
                        idx_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            mode_q       <= OP_ADD;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            result_q     <= '0;
            comp_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mode_q       <= mode_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            result_q     <= result_d;
            comp_start_q <= comp_start_d;
        end
    end

    assign input_enable   = (state_q == ST_INPUT_A) || (state_q == ST_INPUT_B);
    assign mem_addr       = addr_q;
    assign mem_wr         = wr_q;
    assign mem_wdata      = wdata_q;
    assign mode_latched   = mode_q;
    assign comp_start     = comp_start_q;
    assign display_enable = (state_q == ST_DISPLAY);
    assign display_value  = (state_q == ST_DISPLAY) ? result_q : '0;
    assign error          = (state_q == ST_ERROR);
    assign state          = state_q;

endmodule

// File: tb/tb_vector_op_controller.sv
// Directed self-checking bench: one 8-bit/8-element instance with a short
// timeout and one 16-bit/4-element instance.
module tb_vector_op_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // instance A: DATA_W=8, VEC_LEN=8, TIMEOUT_CYC=16
    logic       a_start = 0, a_abort = 0, a_restart = 0, a_rdy = 0, a_done = 0;
    logic [1:0] a_op = '0;
    logic [7:0] a_val = '0, a_res = '0;
    logic       a_in_en, a_mem_wr, a_comp_start, a_disp_en, a_error;
    logic [3:0] a_mem_addr;
    logic [7:0] a_mem_wdata, a_disp_val;
    logic [1:0] a_mode;
    logic [2:0] a_state;

    vector_op_controller #(.DATA_W(8), .VEC_LEN(8), .TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .op_mode(a_op), .abort(a_abort),
        .restart(a_restart), .input_value(a_val), .input_value_ready(a_rdy),
        .input_enable(a_in_en), .mem_addr(a_mem_addr), .mem_wr(a_mem_wr),
        .mem_wdata(a_mem_wdata), .mode_latched(a_mode), .comp_start(a_comp_start),
        .comp_done(a_done), .comp_result(a_res), .display_enable(a_disp_en),
        .display_value(a_disp_val), .error(a_error), .state(a_state)
    );

    // instance B: DATA_W=16, VEC_LEN=4, default timeout
    logic        b_start = 0, b_abort = 0, b_restart = 0, b_rdy = 0, b_done = 0;
    logic [1:0]  b_op = '0;
    logic [15:0] b_val = '0, b_res = '0;
    logic        b_in_en, b_mem_wr, b_comp_start, b_disp_en, b_error;
    logic [2:0]  b_mem_addr;
    logic [15:0] b_mem_wdata, b_disp_val;
    logic [1:0]  b_mode;
    logic [2:0]  b_state;

    vector_op_controller #(.DATA_W(16), .VEC_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .op_mode(b_op), .abort(b_abort),
        .restart(b_restart), .input_value(b_val), .input_value_ready(b_rdy),
        .input_enable(b_in_en), .mem_addr(b_mem_addr), .mem_wr(b_mem_wr),
        .mem_wdata(b_mem_wdata), .mode_latched(b_mode), .comp_start(b_comp_start),
        .comp_done(b_done), .comp_result(b_res), .display_enable(b_disp_en),
        .display_value(b_disp_val), .error(b_error), .state(b_state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ready stays high after the call so successive pushes are back to back
    task automatic push_a(input logic [7:0] v, input int exp_addr);
        a_val = v;
        a_rdy = 1'b1;
        tick();
        check("a_wr", 32'(a_mem_wr), 1);
        check("a_addr", 32'(a_mem_addr), exp_addr);
        check("a_wdata", 32'(a_mem_wdata), 32'(v));
    endtask

    // loads A=a0.., B=b0.. and returns in the second COMPUTE cycle
    task automatic feed_a(input logic [7:0] a0, input logic [7:0] b0);
        for (int i = 0; i < 8; i++) push_a(8'(a0 + i), i);
        check("a_state_after_A", 32'(a_state), 2);
        for (int i = 0; i < 8; i++) push_a(8'(b0 + i), 8 + i);
        a_rdy = 1'b0;
        check("a_state_compute", 32'(a_state), 3);
        check("a_comp_start_hi", 32'(a_comp_start), 1);
        tick();
        check("a_comp_start_lo", 32'(a_comp_start), 0);
        check("a_no_wr_compute", 32'(a_mem_wr), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ticks(2);
        check("rst_state", 32'(a_state), 0);
        check("rst_in_en", 32'(a_in_en), 0);
        check("rst_mem_wr", 32'(a_mem_wr), 0);
        check("rst_mem_addr", 32'(a_mem_addr), 0);
        check("rst_wdata", 32'(a_mem_wdata), 0);
        check("rst_comp_start", 32'(a_comp_start), 0);
        check("rst_disp", 32'(a_disp_en), 0);
        check("rst_error", 32'(a_error), 0);
        check("rst_mode", 32'(a_mode), 0);
        rst = 1'b1;

        a_val = 8'h33; a_rdy = 1'b1;
        tick();
        check("idle_ready_no_wr", 32'(a_mem_wr), 0);
        a_rdy = 1'b0;

        a_start = 1'b1; a_op = 2'd2;
        tick();
        a_start = 1'b0; a_op = 2'd0;
        check("start_state", 32'(a_state), 1);
        check("start_mode", 32'(a_mode), 2);
        check("start_in_en", 32'(a_in_en), 1);

        // result after 10 COMPUTE cycles, with a stray restart ignored
        feed_a(8'd1, 8'd10);
        a_restart = 1'b1;
        tick();
        a_restart = 1'b0;
        check("restart_ign_compute", 32'(a_state), 3);
        ticks(7);
        a_done = 1'b1; a_res = 8'd123;
        tick();
        a_done = 1'b0; a_res = 8'd55;
        check("disp_state", 32'(a_state), 4);
        check("disp_en", 32'(a_disp_en), 1);
        check("disp_val", 32'(a_disp_val), 123);
        a_done = 1'b1; a_res = 8'd77; a_start = 1'b1;
        ticks(3);
        a_done = 1'b0; a_start = 1'b0;
        check("disp_hold_val", 32'(a_disp_val), 123);
        check("disp_hold_state", 32'(a_state), 4);
        a_restart = 1'b1;
        tick();
        a_restart = 1'b0;
        check("restart_state", 32'(a_state), 1);
        check("restart_mode_kept", 32'(a_mode), 2);
        check("restart_disp_off", 32'(a_disp_en), 0);

        // timeout: ERROR 16 cycles after comp_start
        feed_a(8'd20, 8'd40);
        ticks(14);
        check("timeout_k15_state", 32'(a_state), 3);
        tick();
        check("timeout_state", 32'(a_state), 5);
        check("timeout_error", 32'(a_error), 1);
        check("timeout_disp_off", 32'(a_disp_en), 0);
        a_restart = 1'b1;
        tick();
        a_restart = 1'b0;
        check("err_restart_state", 32'(a_state), 1);
        check("err_restart_error", 32'(a_error), 0);

        // done coinciding with timeout expiry wins
        feed_a(8'd60, 8'd80);
        ticks(14);
        a_done = 1'b1; a_res = 8'd200;
        tick();
        a_done = 1'b0;
        check("done_wins_state", 32'(a_state), 4);
        check("done_wins_val", 32'(a_disp_val), 200);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("abort_disp_state", 32'(a_state), 0);

        // abort after the 3rd B element, same cycle as a 4th ready
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 8; i++) push_a(8'(i + 1), i);
        for (int i = 0; i < 3; i++) push_a(8'(10 + i), 8 + i);
        a_val = 8'd99; a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("abort_state", 32'(a_state), 0);
        check("abort_no_wr", 32'(a_mem_wr), 0);
        tick();
        check("abort_no_wr2", 32'(a_mem_wr), 0);
        a_rdy = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        push_a(8'd42, 0);
        check("restart_from_0_state", 32'(a_state), 1);

        // asynchronous reset mid INPUT_A
        a_val = 8'd5;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_state", 32'(a_state), 0);
        check("async_rst_wr", 32'(a_mem_wr), 0);
        check("async_rst_addr", 32'(a_mem_addr), 0);
        check("async_rst_wdata", 32'(a_mem_wdata), 0);
        check("async_rst_mode", 32'(a_mode), 0);
        check("async_rst_in_en", 32'(a_in_en), 0);
        tick();
        rst = 1'b1;
        ticks(2);
        check("post_rst_no_wr", 32'(a_mem_wr), 0);
        check("post_rst_state", 32'(a_state), 0);
        a_rdy = 1'b0;

        // 16-bit, 4-element instance
        b_start = 1'b1; b_op = 2'd3;
        tick();
        b_start = 1'b0;
        check("b_start_state", 32'(b_state), 1);
        check("b_mode", 32'(b_mode), 3);
        b_val = 16'hFFFF; b_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("b_wr", 32'(b_mem_wr), 1);
            check("b_addr", 32'(b_mem_addr), i);
            check("b_wdata", 32'(b_mem_wdata), 32'h0000FFFF);
            if (i == 3) check("b_state_after_A", 32'(b_state), 2);
        end
        b_rdy = 1'b0;
        check("b_state_compute", 32'(b_state), 3);
        check("b_comp_start", 32'(b_comp_start), 1);
        b_done = 1'b1; b_res = 16'hABCD;
        tick();
        b_done = 1'b0;
        check("b_disp_en", 32'(b_disp_en), 1);
        check("b_disp_val", 32'(b_disp_val), 32'h0000ABCD);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_op_controller.md
VECTOR_OP_CONTROLLER -- requirements
Module: vector_op_controller

Interface
REQ-001 Parameter DATA_W, default 8, element and result width in bits.
REQ-002 Parameter VEC_LEN, default 8, elements per vector; legal range 2..128.
REQ-003 Parameter ADDR_W, default clog2(2*VEC_LEN), memory address width.
REQ-004 Parameter TIMEOUT_CYC, default 1024, maximum COMPUTE cycles before error.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; leaves IDLE.
REQ-008 op_mode  in  2  operation selector, sampled only with start.
REQ-009 abort  in  1  one-cycle pulse; returns to IDLE from any state.
REQ-010 restart  in  1  one-cycle pulse; DISPLAY/ERROR back to INPUT_A.
REQ-011 input_value  in  DATA_W  element data.
REQ-012 input_value_ready  in  1  each high cycle while input_enable=1 is one element.
REQ-013 input_enable  out  1  high in INPUT_A and INPUT_B.
REQ-014 mem_addr / mem_wr / mem_wdata  out  ADDR_W / 1 / DATA_W  registered element write port.
REQ-015 mode_latched  out  2  op_mode captured at start.
REQ-016 comp_start  out  1  one-cycle pulse on COMPUTE entry.
REQ-017 comp_done / comp_result  in  1 / DATA_W  compute completion and result.
REQ-018 display_enable / display_value  out  1 / DATA_W  result presentation.
REQ-019 error  out  1  high in ERROR.
REQ-020 state  out  3  current state encoding.

Function
REQ-021 States: IDLE, INPUT_A, INPUT_B, COMPUTE, DISPLAY, ERROR.
REQ-022 IDLE: start -> INPUT_A; mode_latched <= op_mode; element index cleared.
REQ-023 Accepted element in cycle t -> in cycle t+1: mem_wr=1, mem_wdata=value sampled at t, mem_addr=index (A) or VEC_LEN+index (B).
REQ-024 input_value_ready while input_enable=0 is ignored; no write occurs.
REQ-025 Index counts 0..VEC_LEN-1; the element accepted at index VEC_LEN-1 moves INPUT_A->INPUT_B (index cleared) or INPUT_B->COMPUTE in the next cycle.
REQ-026 comp_start high exactly in the first COMPUTE cycle; the timeout counter clears there.
REQ-027 COMPUTE: comp_done -> capture comp_result, enter DISPLAY next cycle.
REQ-028 COMPUTE: counter reaching TIMEOUT_CYC-1 without comp_done -> ERROR.
REQ-029 comp_done in the same cycle as timeout expiry -> DISPLAY; done wins.
REQ-030 comp_done outside COMPUTE is ignored.
REQ-031 DISPLAY: display_enable=1; display_value holds captured result until the state is left.
REQ-032 DISPLAY/ERROR: restart -> INPUT_A; index cleared; mode_latched kept.
REQ-033 abort -> IDLE next cycle from any state, with priority over every other input.
REQ-034 A write already scheduled when abort arrives still completes; no further writes follow.
REQ-035 start is ignored outside IDLE; restart is ignored outside DISPLAY/ERROR.

Reset
REQ-036 rst low forces IDLE immediately, independent of clk.
REQ-037 Outputs under reset: all strobes 0, mem_addr/mem_wdata/display_value 0, error 0, mode_latched 0, counters 0.
REQ-038 Reset asserted mid-input or mid-compute discards all progress; no write is emitted after release.

Structure
REQ-039 State encodings and op_mode codes reside in shared package vec_ctrl_pkg.
REQ-040 The timeout counter is sub-module cycle_timer (clear, enable, expired).

Verification
REQ-041 Defaults: start, A=1..8, B=10..17 -> writes addr 0..7 = 1..8 and 8..15 = 10..17, each one cycle after its ready, then a single comp_start.
REQ-042 comp_done with result 123 after 10 cycles -> DISPLAY, display_enable=1, display_value=123 held until restart.
REQ-043 No comp_done, TIMEOUT_CYC=16 -> ERROR 16 cycles after comp_start, error=1, display_enable=0; restart -> INPUT_A.
REQ-044 abort after the 3rd B element -> IDLE, no further writes; a new start rewrites from addr 0.
REQ-045 VEC_LEN=4, DATA_W=16, values 0xFFFF -> addrs 0..7, B starting at addr 4, full-width data intact.
REQ-046 rst low mid-INPUT_A -> immediate IDLE with all outputs at reset values; ready pulses while IDLE produce no writes.
